// File: rtl/vga_color_ctrl.sv
// ----------------------------------------------------------------------------
// vga_color_ctrl
//
// Purpose:
//   Three push buttons select a colour channel. A debounced press increments
//   that channel by STEP (modulo 16). The new level is committed only on the
//   next vblank_start pulse, so the pixel datapath never sees a colour change
//   in the middle of a frame. Each press commits at most once. A new press is
//   accepted only after all buttons have been stably released.
//
// Ports:
//   clk           pixel-domain clock; all state changes on the rising edge
//   reset         asynchronous, active-low reset
//   btn_n[2:0]    raw active-low buttons ([0]=red, [1]=blue, [2]=green)
//   vblank_start  one-cycle pulse at the first line of vertical blanking
//   red/green/blue[3:0]  committed colour levels
//   pending       high while a debounced press waits for vblank_start
// ----------------------------------------------------------------------------
module vga_color_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int STEP       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_n,
    input  logic       vblank_start,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       pending
);

    // The counter only has to reach DEB_CYCLES-1, so clog2(DEB_CYCLES) bits
    // are enough. The width never drops below 1 bit.
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] TERM   = CW'(DEB_CYCLES - 1);
    localparam logic [3:0]    STEP_V = 4'(STEP);

    // Channel codes match the button index.
    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_BLUE  = 2'd1;
    localparam logic [1:0] CH_GREEN = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PENDING  = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    ch_q, ch_d;
    logic [3:0]    red_q, red_d;
    logic [3:0]    green_q, green_d;
    logic [3:0]    blue_q, blue_d;
    logic [2:0]    btn_s;
    logic          latched_low;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer. The flops reset to "released" so that a button
    // held through reset shows up as a fresh high-to-low edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;

    // The counter saturates at terminal count. It cannot wrap while the
    // controller sits in DEBOUNCE or WAIT_REL.
    assign cnt_inc = (cnt_q == TERM) ? cnt_q : cnt_q + 1'b1;

    // Level of the button latched at press time. This avoids a variable index
    // that could fall outside the 3-bit button vector.
    always_comb begin
        latched_low = 1'b0;
        case (ch_q)
            CH_RED:   latched_low = ~btn_s[0];
            CH_BLUE:  latched_low = ~btn_s[1];
            CH_GREEN: latched_low = ~btn_s[2];
            default:  latched_low = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= CH_RED;
            red_q   <= 4'd0;
            green_q <= 4'd0;
            blue_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;

        case (state_q)
            IDLE: begin
                if (btn_s != 3'b111) begin
                    // Fixed priority: red, then blue, then green.
                    if (!btn_s[0])      ch_d = CH_RED;
                    else if (!btn_s[1]) ch_d = CH_BLUE;
                    else                ch_d = CH_GREEN;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                // Only the latched button matters here. A bounce back high
                // abandons the press without any update. vblank_start is
                // ignored, so a pulse on the same cycle the press completes
                // does not commit.
                if (!latched_low) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TERM) state_d = PENDING;
                end
            end

            PENDING: begin
                // The press is already accepted. Releasing the button does not
                // cancel it; only vblank_start moves the controller on.
                if (vblank_start) begin
                    case (ch_q)
                        CH_RED:   red_d   = red_q   + STEP_V;
                        CH_BLUE:  blue_d  = blue_q  + STEP_V;
                        CH_GREEN: green_d = green_q + STEP_V;
                        default:  ;
                    endcase
                    cnt_d   = '0;
                    state_d = WAIT_REL;
                end
            end

            WAIT_REL: begin
                // All buttons must stay high for a full debounce window before
                // a new press is accepted. This blocks auto-repeat while a
                // button is held.
                if (btn_s == 3'b111) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TERM) state_d = IDLE;
                end else begin
                    cnt_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign red     = red_q;
    assign green   = green_q;
    assign blue    = blue_q;
    assign pending = (state_q == PENDING);

endmodule

// File: tb/tb_vga_color_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_color_ctrl
//
// Purpose:
//   Self-checking bench for vga_color_ctrl, built with DEB_CYCLES=4, STEP=1.
//   Directed scenarios cover the documented use cases. A randomized phase
//   follows. Every cycle, all outputs are compared with a behavioural
//   reference model.
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_vga_color_ctrl;

    localparam int DEB  = 4;
    localparam int STEP = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] btn_n = 3'b111;
    logic       vblank_start = 1'b0;
    logic [3:0] red, green, blue;
    logic       pending;

    int n_cmp = 0;
    int n_err = 0;

    vga_color_ctrl #(.DEB_CYCLES(DEB), .STEP(STEP)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_n        (btn_n),
        .vblank_start (vblank_start),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model
    //   hist: raw button samples in flight through the synchronizer
    //   mode: "idle" waits for a press, "debounce" counts a stable press,
    //         "armed" holds an accepted press until vblank, "release" waits
    //         for all buttons to be stably up
    //   lvl[c]: colour level per button index (0=red, 1=blue, 2=green)
    // ------------------------------------------------------------------------
    logic [2:0] hist[$];
    string      mode;
    int         sel;
    int         run;
    int         lvl[3];

    function automatic void model_reset();
        hist = {3'b111, 3'b111};
        mode = "idle";
        sel  = 0;
        run  = 0;
        lvl  = '{0, 0, 0};
    endfunction

    function automatic void model_edge(input logic [2:0] b, input logic vb);
        logic [2:0] bs;
        bs = hist.pop_front();
        hist.push_back(b);
        if (mode == "idle") begin
            if (bs != 3'b111) begin
                sel  = !bs[0] ? 0 : (!bs[1] ? 1 : 2);
                run  = 0;
                mode = "debounce";
            end
        end else if (mode == "debounce") begin
            if (bs[sel]) mode = "idle";
            else begin
                run++;
                if (run == DEB - 1) mode = "armed";
            end
        end else if (mode == "armed") begin
            if (vb) begin
                lvl[sel] = (lvl[sel] + STEP) % 16;
                run  = 0;
                mode = "release";
            end
        end else begin
            if (bs == 3'b111) begin
                run++;
                if (run == DEB - 1) mode = "idle";
            end else run = 0;
        end
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".red"},     int'(red),     lvl[0]);
        chk({tag, ".blue"},    int'(blue),    lvl[1]);
        chk({tag, ".green"},   int'(green),   lvl[2]);
        chk({tag, ".pending"}, int'(pending), (mode == "armed") ? 1 : 0);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it.
    task automatic step(input string tag, input logic [2:0] b, input logic vb);
        btn_n        = b;
        vblank_start = vb;
        @(posedge clk);
        model_edge(b, vb);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        chk_all({tag, ".rst"});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset state check
        #2;
        chk_all("por");
        chk("por.red_const", int'(red), 0);
        chk("por.pending_const", int'(pending), 0);
        @(negedge clk);
        reset = 1'b1;

        // Red held 20 cycles, vblank at cycle 15
        do_reset("r027");
        for (int i = 0; i < 20; i++) begin
            step("r027", 3'b110, i == 15);
            if (i == 5)  chk("r027.pend_rise", int'(pending), 1);
            if (i == 15) chk("r027.red_after_vb", int'(red), 1);
            if (i == 15) chk("r027.pend_fall", int'(pending), 0);
        end
        for (int i = 0; i < 6; i++) step("r027", 3'b111, 1'b0);
        chk("r027.green0", int'(green), 0);
        chk("r027.blue0", int'(blue), 0);

        // Short blue glitch is rejected
        do_reset("r028");
        for (int i = 0; i < 2; i++) step("r028", 3'b101, i == 1);
        for (int i = 0; i < 40; i++) begin
            step("r028", 3'b111, (i % 10) == 9);
            chk("r028.no_pend", int'(pending), 0);
        end
        chk("r028.blue0", int'(blue), 0);

        // All buttons pressed: red wins; then green alone
        do_reset("r029");
        for (int i = 0; i < 10; i++) step("r029", 3'b000, i == 8);
        for (int i = 0; i < 6; i++)  step("r029", 3'b111, 1'b0);
        for (int i = 0; i < 12; i++) step("r029", 3'b011, i == 9);
        for (int i = 0; i < 6; i++)  step("r029", 3'b111, 1'b0);
        chk("r029.red", int'(red), 1);
        chk("r029.green", int'(green), 1);
        chk("r029.blue", int'(blue), 0);

        // Sixteen red presses wrap back to 0
        do_reset("r030");
        for (int p = 0; p < 16; p++) begin
            for (int i = 0; i < 8; i++) step("r030", 3'b110, i == 7);
            for (int i = 0; i < 6; i++) step("r030", 3'b111, 1'b0);
            if (p == 14) chk("r030.red15", int'(red), 15);
        end
        chk("r030.red_wrap", int'(red), 0);
        chk("r030.green", int'(green), 0);
        chk("r030.blue", int'(blue), 0);

        // Held green across five vblanks commits once
        do_reset("r031");
        for (int i = 0; i < 50; i++) step("r031", 3'b011, (i % 10) == 9);
        for (int i = 0; i < 6; i++)  step("r031", 3'b111, 1'b0);
        chk("r031.green_once", int'(green), 1);

        // Reset during pending discards the update
        do_reset("r032");
        for (int i = 0; i < 8; i++) step("r032", 3'b110, 1'b0);
        chk("r032.pend_before", int'(pending), 1);
        #2;
        btn_n = 3'b111;
        reset = 1'b0;
        model_reset();
        #1;
        chk_all("r032.async");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step("r032", 3'b111, (i % 5) == 4);
        chk("r032.red", int'(red), 0);
        chk("r032.pend", int'(pending), 0);

        // Randomized traffic
        do_reset("rnd");
        begin
            logic [2:0] b;
            b = 3'b111;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0)
                    b = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
                step("rnd", b, $urandom_range(0, 11) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
